// File: rtl/rv32i_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_data_mem_responder
// Description : Responder for the data-memory interface driven by the
//               memory-access stage. Accepts word-addressed load/store
//               requests with byte write masks and commits masked writes to
//               an internal word RAM. Returns read words after WAIT_STATES
//               wait cycles. Flags addresses outside the RAM window.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH_WORDS : number of 32-bit words held (power of 2)
//   ADDR_BASE   : byte address of word 0 (word aligned)
//   WAIT_STATES : extra cycles between accept and ack (0..15)
// Ports
//   i_clk      in   1   clock, rising edge
//   i_rst_n    in   1   asynchronous active-low reset
//   i_req      in   1   request strobe, sampled each rising edge
//   i_wr       in   1   1 = store, 0 = load
//   i_addr     in   32  byte address; bits [1:0] ignored
//   i_wdata    in   32  store data, lane-aligned to the mask
//   i_wr_mask  in   4   byte enables {b3,b2,b1,b0}; stores only
//   o_rdata    out  32  load word; valid only while o_ack=1
//   o_ack      out  1   one-cycle completion pulse
//   o_err      out  1   out-of-range flag; valid only while o_ack=1
//   o_busy     out  1   access accepted and waiting; i_req is ignored
// ============================================================================
module rv32i_data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wr_mask,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_busy
);

    localparam int         c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit         c_ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [31:0]        r_mem [DEPTH_WORDS];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;

    // Request captured on the accept edge, consumed when the access commits
    logic               r_wr;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_in_range;
    logic [31:0]        r_wdata;
    logic [3:0]         r_mask;

    logic               w_accept;
    logic               w_commit;

    // ------------------------------------------------------------------------
    // Address decode (32-bit unsigned arithmetic; wraps below ADDR_BASE are
    // caught by the explicit lower-bound compare)
    // ------------------------------------------------------------------------
    logic [31:0]        w_off;
    logic [31:0]        w_word;
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_unused_off;

    assign w_off        = i_addr - ADDR_BASE;
    assign w_word       = {2'b00, w_off[31:2]};
    assign w_in_range   = (i_addr >= ADDR_BASE) && (w_word < 32'(DEPTH_WORDS));
    assign w_idx        = w_word[c_IDX_W-1:0];
    assign w_unused_off = ^w_off[1:0];

    // ------------------------------------------------------------------------
    // Commit operands. With zero wait states the access commits on its own
    // accept edge, so it must come straight from the inputs; otherwise it
    // comes from the captured request.
    // ------------------------------------------------------------------------
    logic               w_c_wr;
    logic [c_IDX_W-1:0] w_c_idx;
    logic               w_c_in_range;
    logic [31:0]        w_c_wdata;
    logic [3:0]         w_c_mask;
    logic               w_mem_we;

    assign w_c_wr       = c_ZERO_WAIT ? i_wr       : r_wr;
    assign w_c_idx      = c_ZERO_WAIT ? w_idx      : r_idx;
    assign w_c_in_range = c_ZERO_WAIT ? w_in_range : r_in_range;
    assign w_c_wdata    = c_ZERO_WAIT ? i_wdata    : r_wdata;
    assign w_c_mask     = c_ZERO_WAIT ? i_wr_mask  : r_mask;

    // Gate with reset so a request presented while reset is held can never
    // reach the RAM, which itself has no reset.
    assign w_mem_we     = w_commit && w_c_wr && w_c_in_range && i_rst_n;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;

        case (r_state)
            S_IDLE, S_RESP: begin
                if (i_req) begin
                    w_accept = 1'b1;
                    if (c_ZERO_WAIT) begin
                        w_state_nxt = S_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WAIT_LOAD;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, captured request and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_wr       <= 1'b0;
            r_idx      <= '0;
            r_in_range <= 1'b0;
            r_wdata    <= 32'd0;
            r_mask     <= 4'd0;
            o_rdata    <= 32'd0;
            o_ack      <= 1'b0;
            o_err      <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;

            if (w_accept) begin
                r_wr       <= i_wr;
                r_idx      <= w_idx;
                r_in_range <= w_in_range;
                r_wdata    <= i_wdata;
                r_mask     <= i_wr_mask;
            end

            o_ack  <= w_commit;
            o_err  <= w_commit && !w_c_in_range;
            o_busy <= (w_state_nxt == S_WAIT);

            // The RAM write lands with a non-blocking update, so a load reads
            // the word as it stood before this edge's commit.
            if (w_commit && !w_c_wr && w_c_in_range) begin
                o_rdata <= r_mem[w_c_idx];
            end else begin
                o_rdata <= 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Byte-masked RAM write (contents survive reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_c_mask[k]) begin
                    r_mem[w_c_idx][8*k +: 8] <= w_c_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
